bht_branch_predict: RTL
=======================

BHT_BRANCH_PREDICT -- requirements
Module: bht_branch_predict

Interface
REQ-001 SHALL have parameter BHT_DEPTH, default 64, number of 2-bit counter entries (power of two, 4..1024).
REQ-002 SHALL have parameter HIST_W, default 6, global-history width (1..log2(BHT_DEPTH)).
REQ-003 SHALL have parameter TAKEN_LIMIT, default 32'h4000_3D00, exclusive upper bound on predicted-taken targets.
REQ-004 clk_i  input  1  core clock; all state on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 fetch_rdata_i  input  32  fetched instruction; compressed in [15:0].
REQ-007 fetch_pc_i  input  32  PC of fetched instruction.
REQ-008 fetch_valid_i  input  1  fetch instruction valid.
REQ-009 spec_o  output  predict_info_t  prediction (taken, pc).
REQ-010 fetch_hist_o  output  HIST_W  history snapshot used for this prediction, carried down the pipe.
REQ-011 ex_valid_i  input  1  execute-stage resolution valid.
REQ-012 ex_is_branch_i  input  1  resolved instruction is conditional branch (B or C.BEQZ/C.BNEZ).
REQ-013 ex_pc_i  input  32  PC of resolved branch.
REQ-014 ex_taken_i  input  1  actual branch outcome.
REQ-015 ex_hist_i  input  HIST_W  fetch_hist_o value that accompanied the resolved branch.

Function
REQ-016 Decode SHALL classify J (opcode 0x6f), B (0x63), CJ (op 01, funct3 101/001), CB (op 01, funct3 110/111); spec_o.pc = fetch_pc_i + sign-extended J/B/CJ/CB immediate, B immediate when none match; 32-bit wrap.
REQ-017 Fetch index SHALL be fetch_pc_i[IDX_W:1], IDX_W = log2(BHT_DEPTH) (halfword granularity).
REQ-018 spec_o.taken SHALL = fetch_valid_i & (J | CJ | ((B | CB) & ctr[idx][1])) & (spec_o.pc < TAKEN_LIMIT), purely combinational, zero-cycle latency.
REQ-019 Counters SHALL be 2-bit saturating: taken increments (stop at 11), not-taken decrements (stop at 00).
REQ-020 On ex_valid_i & ex_is_branch_i, counter at update index SHALL change on next edge; otherwise no table change.
REQ-021 Update index SHALL be ex_pc_i[IDX_W:1] (XORed per REQ-028 when enabled).
REQ-022 Same-cycle fetch read and update to same index: prediction SHALL use pre-update value (no bypass).
REQ-023 fetch_hist_o SHALL equal current GHR; all zeros when GSHARE_EN undefined.
REQ-024 Jumps and non-branch resolutions SHALL NOT alter counters or GHR.

Reset
REQ-025 On rst_ni low, all counters SHALL asynchronously become 01 (weakly not-taken) and GHR all zeros.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight update; first edge after deassert SHALL accept updates normally.
REQ-027 During reset spec_o.taken SHALL follow REQ-018 with counters at 01 (branches not taken, jumps taken).

Configuration
REQ-028 With GSHARE_EN defined: fetch index = pc index XOR zero-extended GHR; update index = ex pc index XOR ex_hist_i; on each branch update GHR shifts left with ex_taken_i in bit 0.
REQ-029 Without GSHARE_EN: pure bimodal, no GHR register, ex_hist_i ignored.

Verification
REQ-030 Reset, fetch B at pc 0x100, offset -8 -> taken=0, pc=0xF8 (counter 01).
REQ-031 Two taken updates for pc 0x100 -> counter 11; fetch -> taken=1, pc=0xF8; four not-taken -> saturates 00, taken=0.
REQ-032 Fetch JAL at pc 0x4000_3CF0, offset +0x20 -> pc=0x4000_3D10, taken=0 (limit); offset -0x20 -> taken=1.
REQ-033 Same-cycle update and fetch at pc 0x200 with counter 01, update taken -> taken=0 this cycle, 1 next cycle.
REQ-034 GSHARE_EN, HIST_W=6: three taken branch updates -> fetch_hist_o=6'b000111; pc 0x0 fetch reads entry 7.
REQ-035 Assert rst_ni low coincident with update -> after release counter=01, GHR=0.

Source files
------------

// File: rtl/bht_branch_predict_if.sv
// Fetch/predict and execute/resolve bundle between the core and the branch predictor.
// The master side is the core pipeline and the slave side is the predictor.
interface bht_branch_predict_if #(
  parameter int HIST_W = 6
);
  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
  } predict_info_t;

  logic [31:0]       fetch_rdata_i;
  logic [31:0]       fetch_pc_i;
  logic              fetch_valid_i;
  predict_info_t     spec_o;
  logic [HIST_W-1:0] fetch_hist_o;

  logic              ex_valid_i;
  logic              ex_is_branch_i;
  logic [31:0]       ex_pc_i;
  logic              ex_taken_i;
  logic [HIST_W-1:0] ex_hist_i;

  modport master (
    output fetch_rdata_i, fetch_pc_i, fetch_valid_i,
    output ex_valid_i, ex_is_branch_i, ex_pc_i, ex_taken_i, ex_hist_i,
    input  spec_o, fetch_hist_o
  );

  modport slave (
    input  fetch_rdata_i, fetch_pc_i, fetch_valid_i,
    input  ex_valid_i, ex_is_branch_i, ex_pc_i, ex_taken_i, ex_hist_i,
    output spec_o, fetch_hist_o
  );
endinterface

// File: rtl/bht_branch_predict.sv
// Fetch-stage branch predictor: 2-bit saturating counter table indexed by PC.
// Define GSHARE_EN to XOR a global-history register into the table index.
module bht_branch_predict #(
  parameter int          BHT_DEPTH   = 64,
  parameter int          HIST_W      = 6,
  parameter logic [31:0] TAKEN_LIMIT = 32'h4000_3D00
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  bht_branch_predict_if.slave   bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  typedef logic [IDX_W-1:0] idx_t;

  logic [1:0]  ctr_q [BHT_DEPTH];
  logic [1:0]  ctr_d;
  logic [31:0] instr;
  logic        is_j, is_b, is_cj, is_cb;
  logic [31:0] imm_j, imm_b, imm_cj, imm_cb, imm;
  logic [31:0] target;
  logic        below_limit;
  logic        taken;
  idx_t        fetch_idx;
  idx_t        upd_idx;
  logic        upd_en;

  assign instr = bus.fetch_rdata_i;

  // Compressed forms are recognised on the low halfword; 32-bit opcodes always have [1:0]=11.
  assign is_j  = (instr[6:0] == 7'h6f);
  assign is_b  = (instr[6:0] == 7'h63);
  assign is_cj = (instr[1:0] == 2'b01) && ((instr[15:13] == 3'b101) || (instr[15:13] == 3'b001));
  assign is_cb = (instr[1:0] == 2'b01) && ((instr[15:13] == 3'b110) || (instr[15:13] == 3'b111));

  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_cj = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
                   instr[2], instr[11], instr[5:3], 1'b0};
  assign imm_cb = {{23{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10],
                   instr[4:3], 1'b0};

  always_comb begin
    imm = imm_b;
    if (is_j)       imm = imm_j;
    else if (is_b)  imm = imm_b;
    else if (is_cj) imm = imm_cj;
    else if (is_cb) imm = imm_cb;
  end

  assign target      = bus.fetch_pc_i + imm;
  assign below_limit = (target < TAKEN_LIMIT);
  assign upd_en      = bus.ex_valid_i & bus.ex_is_branch_i;

`ifdef GSHARE_EN
  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_d;

  assign fetch_idx        = bus.fetch_pc_i[IDX_W:1] ^ IDX_W'(ghr_q);
  assign upd_idx          = bus.ex_pc_i[IDX_W:1] ^ IDX_W'(bus.ex_hist_i);
  assign ghr_d            = (ghr_q << 1) | HIST_W'(bus.ex_taken_i);
  assign bus.fetch_hist_o = ghr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr_q <= '0;
    end else if (upd_en) begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign fetch_idx        = bus.fetch_pc_i[IDX_W:1];
  assign upd_idx          = bus.ex_pc_i[IDX_W:1];
  assign bus.fetch_hist_o = '0;
`endif

  // Table read is the registered value, so a same-cycle update to this entry is not bypassed.
  assign taken = bus.fetch_valid_i &
                 (is_j | is_cj | ((is_b | is_cb) & ctr_q[fetch_idx][1])) &
                 below_limit;

  assign bus.spec_o = {taken, target};

  always_comb begin
    ctr_d = ctr_q[upd_idx];
    if (bus.ex_taken_i) begin
      if (ctr_q[upd_idx] != 2'b11) ctr_d = ctr_q[upd_idx] + 2'b01;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) ctr_d = ctr_q[upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_en) begin
      ctr_q[upd_idx] <= ctr_d;
    end
  end
endmodule
